// File: rtl/spi_bus_arbiter_if.sv
// Requester-side handshake and SPI pin bundle for the round-robin SPI arbiter.
// The master modport is the arbiter's view; slave is the system/bus side.
interface spi_bus_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int NUM_SLAVES = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int SLV_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*SLV_W-1:0]      req_slave;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic                          busy;
    logic                          sclk;
    logic                          mosi;
    logic                          miso;
    logic [NUM_SLAVES-1:0]         cs_n;

    modport master (
        input  req_valid, req_slave, req_data, miso,
        output req_ready, rsp_valid, rsp_data, busy, sclk, mosi, cs_n
    );

    modport slave (
        output req_valid, req_slave, req_data, miso,
        input  req_ready, rsp_valid, rsp_data, busy, sclk, mosi, cs_n
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one Mode-0 SPI bus among NUM_REQ requesters.
// One word per grant, MSB first; sclk/mosi/cs_n come straight from flops.
module spi_bus_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int NUM_SLAVES = 4,
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic              clk,
    input  logic              rst,
    spi_bus_arbiter_if.master bus
);
    localparam int SLV_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_DONE,
        S_GAP
    } state_t;

    state_t                state_q, state_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [PTR_W-1:0]      owner_q, owner_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic                  low_q, low_d;
    logic [SLV_W-1:0]      slave_q, slave_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic [NUM_SLAVES-1:0] cs_n_q, cs_n_d;

    logic                  gnt_found;
    logic [PTR_W-1:0]      gnt_idx;
    logic                  active_d;

    // First requesting index at or after ptr, wrapping; MSB of result = found.
    function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                               input logic [PTR_W-1:0]   ptr);
        logic [PTR_W:0] res;
        int             idx;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (vld[idx]) begin
                res = {1'b1, PTR_W'(idx)};
            end
        end
        return res;
    endfunction

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        div_d   = div_q;
        bit_d   = bit_q;
        low_d   = low_q;
        slave_d = slave_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        {gnt_found, gnt_idx} = rr_pick(bus.req_valid, ptr_q);

        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    state_d = S_SETUP;
                    owner_d = gnt_idx;
                    ptr_d   = PTR_W'((int'(gnt_idx) + 1) % NUM_REQ);
                    slave_d = bus.req_slave[gnt_idx*SLV_W +: SLV_W];
                    tx_d    = bus.req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
                    div_d   = '0;
                end
            end
            S_SETUP: begin
                if (div_q == DIV_LAST) begin
                    // Leaving SETUP raises sclk for bit 0, so miso is sampled here.
                    state_d = S_SHIFT;
                    div_d   = '0;
                    low_d   = 1'b0;
                    bit_d   = '0;
                    rx_d    = {rx_q[DATA_WIDTH-2:0], bus.miso};
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (!low_q) begin
                        low_d = 1'b1;
                        if (bit_q != BIT_LAST) begin
                            tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                        if (bit_q == BIT_LAST) begin
                            state_d = S_HOLD;
                        end else begin
                            low_d = 1'b0;
                            rx_d  = {rx_q[DATA_WIDTH-2:0], bus.miso};
                        end
                    end
                end
            end
            S_HOLD: begin
                if (div_q == DIV_LAST) begin
                    state_d = S_DONE;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_GAP;
                div_d   = '0;
            end
            S_GAP: begin
                if (div_q == DIV_LAST) begin
                    state_d = S_IDLE;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pin values are computed from the next state so the pins are plain flops.
    always_comb begin
        active_d = (state_d == S_SETUP) || (state_d == S_SHIFT) || (state_d == S_HOLD);
        sclk_d   = (state_d == S_SHIFT) && !low_d;
        mosi_d   = active_d && tx_d[DATA_WIDTH-1];
        cs_n_d   = '1;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            if (active_d && (slave_d == SLV_W'(s))) begin
                cs_n_d[s] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            low_q   <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= '1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            low_q   <= low_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
        end
    end

    // Transaction payload; only observed in states that have loaded it.
    always_ff @(posedge clk) begin
        owner_q <= owner_d;
        slave_q <= slave_d;
        tx_q    <= tx_d;
        rx_q    <= rx_d;
    end

    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        bus.rsp_data  = '0;
        if ((state_q == S_IDLE) && gnt_found) begin
            bus.req_ready[gnt_idx] = 1'b1;
        end
        if (state_q == S_DONE) begin
            bus.rsp_valid[owner_q] = 1'b1;
            bus.rsp_data           = rx_q;
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.sclk = sclk_q;
    assign bus.mosi = mosi_q;
    assign bus.cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: vector table of single transactions plus
// hand-written sequences for arbitration order, back-to-back gap, reset abort and CLK_DIV=1.
module tb_spi_bus_arbiter;
    logic clk;
    logic rst;

    spi_bus_arbiter_if #(.NUM_REQ(4), .NUM_SLAVES(4), .DATA_WIDTH(8)) bus0 ();
    spi_bus_arbiter_if #(.NUM_REQ(4), .NUM_SLAVES(4), .DATA_WIDTH(8)) bus1 ();

    spi_bus_arbiter #(.NUM_REQ(4), .NUM_SLAVES(4), .DATA_WIDTH(8), .CLK_DIV(4)) dut0 (
        .clk(clk),
        .rst(rst),
        .bus(bus0)
    );

    spi_bus_arbiter #(.NUM_REQ(4), .NUM_SLAVES(4), .DATA_WIDTH(8), .CLK_DIV(1)) dut1 (
        .clk(clk),
        .rst(rst),
        .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Slave model for dut0: loopback or a Mode-0 shift register changing on sclk fall.
    logic       loop_mode;
    logic       slv_load;
    logic [7:0] slv_word;
    logic [7:0] slv_sh;
    logic       sclk_prev;
    logic [7:0] mosi_cap;

    always @(posedge clk) begin
        sclk_prev <= bus0.sclk;
        if (slv_load) slv_sh <= slv_word;
        else if (sclk_prev && !bus0.sclk) slv_sh <= {slv_sh[6:0], 1'b0};
    end

    always_comb bus0.miso = loop_mode ? bus0.mosi : slv_sh[7];
    always_comb bus1.miso = bus1.mosi;

    always @(posedge bus0.sclk) mosi_cap <= {mosi_cap[6:0], bus0.mosi};

    typedef struct {
        int         req;
        logic [1:0] slave;
        logic [7:0] tx;
        logic       loop;
        logic [7:0] slv_word;
        logic [3:0] exp_ready;
        logic [3:0] exp_cs;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req0(input int idx, input logic [1:0] slv, input logic [7:0] data);
        bus0.req_slave[idx*2 +: 2] = slv;
        bus0.req_data[idx*8 +: 8]  = data;
        bus0.req_valid[idx]        = 1'b1;
    endtask

    task automatic wait_ready(output logic [3:0] rdy);
        int n;
        n = 0;
        #1;
        while (bus0.req_ready == 4'b0 && n < 200) begin
            tick();
            #1;
            n++;
        end
        rdy = bus0.req_ready;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (bus0.rsp_valid == 4'b0 && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int         lat;
        int         cs_err;
        logic [3:0] rdy;
        loop_mode = v.loop;
        slv_word  = v.slv_word;
        slv_load  = 1'b1;
        bus0.req_valid = '0;
        set_req0(v.req, v.slave, v.tx);
        wait_ready(rdy);
        check("grant", rdy, v.exp_ready);
        tick();
        check("ready_pulse", bus0.req_ready, 4'b0);
        bus0.req_valid = '0;
        slv_load = 1'b0;
        lat    = 1;
        cs_err = 0;
        while (bus0.rsp_valid == 4'b0 && lat < 200) begin
            if (bus0.cs_n !== v.exp_cs) cs_err++;
            tick();
            lat++;
        end
        check("latency", lat, 73);
        check("cs_n_active", cs_err, 0);
        check("rsp_valid", bus0.rsp_valid, v.exp_ready);
        check("rsp_data", bus0.rsp_data, v.exp_rx);
        check("mosi_bits", mosi_cap, v.tx);
        check("cs_n_done", bus0.cs_n, 4'hF);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] rdy;
        logic [4:0] ev[8];
        int         ev_n;
        int         n;
        int         cnt;
        int         sclk_err;
        int         hi;

        rst = 1'b1;
        loop_mode = 1'b1;
        slv_load  = 1'b0;
        slv_word  = '0;
        bus0.req_valid = '0;
        bus0.req_slave = '0;
        bus0.req_data  = '0;
        bus1.req_valid = '0;
        bus1.req_slave = '0;
        bus1.req_data  = '0;

        vecs[0] = '{req: 0, slave: 2'd1, tx: 8'hA5, loop: 1'b1, slv_word: 8'h00,
                    exp_ready: 4'b0001, exp_cs: 4'b1101, exp_rx: 8'hA5};
        vecs[1] = '{req: 2, slave: 2'd3, tx: 8'h00, loop: 1'b0, slv_word: 8'h3C,
                    exp_ready: 4'b0100, exp_cs: 4'b0111, exp_rx: 8'h3C};
        vecs[2] = '{req: 1, slave: 2'd0, tx: 8'h5A, loop: 1'b1, slv_word: 8'h00,
                    exp_ready: 4'b0010, exp_cs: 4'b1110, exp_rx: 8'h5A};
        vecs[3] = '{req: 3, slave: 2'd2, tx: 8'h81, loop: 1'b0, slv_word: 8'hC3,
                    exp_ready: 4'b1000, exp_cs: 4'b1011, exp_rx: 8'hC3};

        do_reset();
        check("rst_req_ready", bus0.req_ready, 4'b0);
        check("rst_rsp_valid", bus0.rsp_valid, 4'b0);
        check("rst_rsp_data", bus0.rsp_data, 8'h00);
        check("rst_busy", bus0.busy, 1'b0);
        check("rst_sclk", bus0.sclk, 1'b0);
        check("rst_mosi", bus0.mosi, 1'b0);
        check("rst_cs_n", bus0.cs_n, 4'hF);

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // All four requesting: strict round-robin, each response before the next grant.
        do_reset();
        loop_mode = 1'b1;
        for (int i = 0; i < 4; i++) set_req0(i, 2'(i), 8'(8'h10 + i));
        for (int i = 0; i < 8; i++) ev[i] = '0;
        ev_n = 0;
        n    = 0;
        #1;
        while (ev_n < 8 && n < 600) begin
            if (bus0.req_ready != 4'b0) begin
                ev[ev_n] = {1'b0, bus0.req_ready};
                ev_n++;
            end else if (bus0.rsp_valid != 4'b0) begin
                ev[ev_n] = {1'b1, bus0.rsp_valid};
                ev_n++;
            end
            tick();
            #1;
            n++;
        end
        for (int i = 0; i < 8; i++) begin
            check("rr_order", ev[i], {(i % 2 == 1) ? 1'b1 : 1'b0, 4'(4'b0001 << (i / 2))});
        end

        bus0.req_valid = 4'b1001;
        wait_ready(rdy);
        check("rr_wrap_first", rdy, 4'b0001);
        tick();
        bus0.req_valid[0] = 1'b0;
        wait_ready(rdy);
        check("rr_wrap_second", rdy, 4'b1000);
        tick();
        bus0.req_valid = '0;
        wait_rsp(n);
        check("rr_wrap_rsp", bus0.rsp_valid, 4'b1000);
        check("rr_wrap_data", bus0.rsp_data, 8'h13);

        // Back-to-back from requester 1: deselect window length and sclk idle.
        loop_mode = 1'b1;
        set_req0(1, 2'd2, 8'h69);
        wait_ready(rdy);
        check("b2b_grant", rdy, 4'b0010);
        tick();
        wait_rsp(n);
        check("b2b_rsp1", bus0.rsp_data, 8'h69);
        cnt      = 0;
        sclk_err = 0;
        while (bus0.cs_n == 4'hF && cnt < 50) begin
            if (bus0.sclk !== 1'b0) sclk_err++;
            cnt++;
            tick();
        end
        bus0.req_valid = '0;
        check("b2b_gap_len", cnt, 6);
        check("b2b_gap_sclk", sclk_err, 0);
        check("b2b_cs_n_next", bus0.cs_n, 4'b1011);
        wait_rsp(n);
        check("b2b_rsp2", bus0.rsp_valid, 4'b0010);
        check("b2b_data2", bus0.rsp_data, 8'h69);

        // Reset during bit 4 of SHIFT; pointer must return to 0.
        set_req0(2, 2'd0, 8'h96);
        set_req0(3, 2'd2, 8'h33);
        wait_ready(rdy);
        check("abort_grant", rdy, 4'b0100);
        tick();
        repeat (38) tick();
        check("abort_mid_busy", bus0.busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_cs_n", bus0.cs_n, 4'hF);
        check("abort_sclk", bus0.sclk, 1'b0);
        check("abort_busy", bus0.busy, 1'b0);
        check("abort_rsp_valid", bus0.rsp_valid, 4'b0);
        check("abort_mosi", bus0.mosi, 1'b0);
        #1;
        check("abort_regrant", bus0.req_ready, 4'b0100);
        tick();
        bus0.req_valid = '0;
        wait_rsp(n);
        check("abort_latency", n + 1, 73);
        check("abort_rsp", bus0.rsp_valid, 4'b0100);
        check("abort_data", bus0.rsp_data, 8'h96);

        // CLK_DIV=1 instance: 2-cycle sclk period, 19-cycle latency.
        bus1.req_slave[1:0] = 2'd0;
        bus1.req_data[7:0]  = 8'hFF;
        bus1.req_valid      = 4'b0001;
        #1;
        check("div1_grant", bus1.req_ready, 4'b0001);
        tick();
        bus1.req_valid = '0;
        n  = 0;
        hi = 0;
        while (bus1.rsp_valid == 4'b0 && n < 100) begin
            if (bus1.sclk) hi++;
            tick();
            n++;
        end
        check("div1_latency", n + 1, 19);
        check("div1_sclk_high", hi, 8);
        check("div1_rsp", bus1.rsp_valid, 4'b0001);
        check("div1_data", bus1.rsp_data, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
